// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared constants for the regfile write-back path (the values that used to
//   live in defines.v) plus the write-port source select type.
//   RegBus      : register data width
//   RegAddrBus  : register address width
//   RegNumLog2  : log2 of the number of architectural registers
//   WbBufDepth  : long-latency write-back buffer depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegNumLog2 = 5;
    localparam int unsigned RegAddrBus = RegNumLog2;
    localparam int unsigned WbBufDepth = 4;

    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    // Who drives the regfile write port in the next cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_BUF  = 2'd2
    } wb_sel_e;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_wb_pend_buf.sv
// -----------------------------------------------------------------------------
// wb_pend_buf
//   Ordered ring buffer of pending long-latency write-backs. Each entry carries
//   a valid bit that is cleared when a newer pipeline write to the same register
//   squashes it; invalid entries still occupy a slot until popped.
//   Optional macro WB_PERF_CNT_EN adds sq_num_o (entries squashed this cycle).
//
//   push_i/push_addr_i/push_data_i : enqueue at tail (caller guarantees !full_o)
//   pop_i                          : dequeue head (caller guarantees count_o!=0)
//   sq_en_i/sq_addr_i              : invalidate valid entries matching address
//   chk_addr1_i/chk_addr2_i        : decode read addresses for hazard check
//   full_o/count_o                 : occupancy
//   head_vld_o/head_addr_o/head_data_o : head entry contents
//   hit1_o/hit2_o                  : check address matches a valid entry
// -----------------------------------------------------------------------------
module wb_pend_buf
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RegBus,
    parameter int unsigned ADDR_W = RegAddrBus,
    parameter int unsigned DEPTH  = WbBufDepth,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              sq_en_i,
    input  logic [ADDR_W-1:0] sq_addr_i,
    input  logic [ADDR_W-1:0] chk_addr1_i,
    input  logic [ADDR_W-1:0] chk_addr2_i,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              head_vld_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              hit1_o,
`ifdef WB_PERF_CNT_EN
    output logic [CNT_W-1:0]  sq_num_o,
`endif
    output logic              hit2_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  sq_hit;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sq_hit[i] = sq_en_i && vld_q[i] && (addr_q[i] == sq_addr_i);
        end
    end

    // Squash is applied before the push so an entry written this edge with the
    // same address survives: it is program-newer than the pipeline write.
    always_comb begin
        vld_d = vld_q & ~sq_hit;
        if (pop_i) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            vld_d[wr_ptr_q] = (push_addr_i != '0);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; the valid bits and count guard it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit1_o = hit1_o | (vld_q[i] && (addr_q[i] == chk_addr1_i));
            hit2_o = hit2_o | (vld_q[i] && (addr_q[i] == chk_addr2_i));
        end
        hit1_o = hit1_o && (chk_addr1_i != '0);
        hit2_o = hit2_o && (chk_addr2_i != '0);
    end

`ifdef WB_PERF_CNT_EN
    always_comb begin
        sq_num_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sq_num_o = sq_num_o + CNT_W'(sq_hit[i]);
        end
    end
`endif

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign count_o     = count_q;
    assign head_vld_o  = vld_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

endmodule : wb_pend_buf

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Sole writer of the regfile write port. Pipeline write-backs always own the
//   port; long-latency results are buffered in order and drain into idle port
//   cycles. Pending buffered writes are reported to decode as hazards.
//   Optional macro WB_PERF_CNT_EN adds the sq_cnt / full_cyc counters.
//
//   clk, rst (async, active-low)
//   pipe_we/pipe_waddr/pipe_wdata      : in-order write-back stream
//   lat_valid/lat_ready/lat_waddr/lat_wdata : long-latency result handshake
//   chk_raddr1/chk_raddr2, pend_hit1/pend_hit2 : decode hazard query
//   we/waddr/wdata                     : registered regfile write port
//   sq_cnt/full_cyc (macro only)       : saturating squash / full-cycle counts
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RegBus,
    parameter int unsigned ADDR_W = RegAddrBus,
    parameter int unsigned DEPTH  = WbBufDepth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              lat_valid,
    output logic              lat_ready,
    input  logic [ADDR_W-1:0] lat_waddr,
    input  logic [DATA_W-1:0] lat_wdata,
    input  logic [ADDR_W-1:0] chk_raddr1,
    input  logic [ADDR_W-1:0] chk_raddr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
`ifdef WB_PERF_CNT_EN
    output logic [15:0]       sq_cnt,
    output logic [15:0]       full_cyc,
`endif
    output logic [DATA_W-1:0] wdata
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              sq_en, push, pop;
    logic              buf_full;
    logic [CNT_W-1:0]  buf_count;
    logic              head_vld;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    wb_sel_e           sel;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0]  sq_num;
    logic [16:0]       sq_sum;
    logic [15:0]       sq_cnt_q, sq_cnt_d;
    logic [15:0]       full_cyc_q, full_cyc_d;
`endif

    // A pipe write to x0 still holds the port (no drain) but writes nothing
    // and squashes nothing.
    assign sq_en     = pipe_we && (pipe_waddr != '0);
    assign push      = lat_valid && !buf_full;
    assign pop       = !pipe_we && (buf_count != '0);
    assign lat_ready = !buf_full;

    wb_pend_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (lat_waddr),
        .push_data_i (lat_wdata),
        .pop_i       (pop),
        .sq_en_i     (sq_en),
        .sq_addr_i   (pipe_waddr),
        .chk_addr1_i (chk_raddr1),
        .chk_addr2_i (chk_raddr2),
        .full_o      (buf_full),
        .count_o     (buf_count),
        .head_vld_o  (head_vld),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .hit1_o      (pend_hit1),
`ifdef WB_PERF_CNT_EN
        .sq_num_o    (sq_num),
`endif
        .hit2_o      (pend_hit2)
    );

    always_comb begin
        sel = SEL_NONE;
        if (sq_en) begin
            sel = SEL_PIPE;
        end else if (pop && head_vld) begin
            sel = SEL_BUF;
        end
    end

    // Address/data hold their last value on idle cycles.
    always_comb begin
        we_d    = WriteDisable;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (sel)
            SEL_PIPE: begin
                we_d    = WriteEnable;
                waddr_d = pipe_waddr;
                wdata_d = pipe_wdata;
            end
            SEL_BUF: begin
                we_d    = WriteEnable;
                waddr_d = head_addr;
                wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= WriteDisable;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

`ifdef WB_PERF_CNT_EN
    assign sq_sum = {1'b0, sq_cnt_q} + 17'(sq_num);

    always_comb begin
        sq_cnt_d   = sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
        full_cyc_d = full_cyc_q;
        if (buf_full && (full_cyc_q != 16'hFFFF)) begin
            full_cyc_d = full_cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_cnt_q   <= '0;
            full_cyc_q <= '0;
        end else begin
            sq_cnt_q   <= sq_cnt_d;
            full_cyc_q <= full_cyc_d;
        end
    end

    assign sq_cnt   = sq_cnt_q;
    assign full_cyc = full_cyc_q;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_waddr;
    logic [31:0] lat_wdata;
    logic [4:0]  chk_raddr1, chk_raddr2;
    logic        pend_hit1, pend_hit2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_PERF_CNT_EN
    logic [15:0] sq_cnt, full_cyc;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lat_valid  (lat_valid),
        .lat_ready  (lat_ready),
        .lat_waddr  (lat_waddr),
        .lat_wdata  (lat_wdata),
        .chk_raddr1 (chk_raddr1),
        .chk_raddr2 (chk_raddr2),
        .pend_hit1  (pend_hit1),
        .pend_hit2  (pend_hit2),
        .we         (we),
        .waddr      (waddr),
`ifdef WB_PERF_CNT_EN
        .sq_cnt     (sq_cnt),
        .full_cyc   (full_cyc),
`endif
        .wdata      (wdata)
    );

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  c1, c2;
        logic        rdy, h1, h2;
    } vec_t;

    typedef struct { logic [4:0] a; logic [31:0] d; logic v; } ent_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

    ent_t        mq[$];   // reference buffer contents
    wr_t         sb[$];   // expected port writes
    logic [4:0]  last_a;
    logic [31:0] last_d;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vt[30];
    vec_t        rv[3];

    function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic rdy, input logic h1, input logic h2);
        vec_t v;
        v.pw = pw; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
        v.c1 = c1; v.c2 = c2; v.rdy = rdy; v.h1 = h1; v.h2 = h2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge.
    task automatic model_step(input vec_t v);
        int sz;
        ent_t e;
        sz = mq.size();
        if (v.pw) begin
            if (v.pa != 5'd0) begin
                sb.push_back('{v.pa, v.pd});
                foreach (mq[i]) if (mq[i].v && mq[i].a == v.pa) mq[i].v = 1'b0;
            end
        end else if (sz > 0) begin
            e = mq.pop_front();
            if (e.v) sb.push_back('{e.a, e.d});
        end
        if (v.lv && sz < 4) mq.push_back('{v.la, v.ld, (v.la != 5'd0)});
    endtask

    task automatic check_port(input string tag);
        wr_t w;
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL %s unexpected_write: got we=1 addr=%0d data=%0h expected we=0", tag, waddr, wdata);
            end else begin
                w = sb.pop_front();
                check({tag, " waddr"}, 32'(waddr), 32'(w.a));
                check({tag, " wdata"}, wdata, w.d);
                last_a = w.a;
                last_d = w.d;
            end
        end else begin
            if (sb.size() != 0) begin
                w = sb.pop_front();
                n_err++;
                $display("FAIL %s missing_write: got we=%b expected we=1 addr=%0d data=%0h", tag, we, w.a, w.d);
            end
            check({tag, " hold_waddr"}, 32'(waddr), 32'(last_a));
            check({tag, " hold_wdata"}, wdata, last_d);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        pipe_we = v.pw; pipe_waddr = v.pa; pipe_wdata = v.pd;
        lat_valid = v.lv; lat_waddr = v.la; lat_wdata = v.ld;
        chk_raddr1 = v.c1; chk_raddr2 = v.c2;
        #1;
        check({tag, " lat_ready"}, 32'(lat_ready), 32'(v.rdy));
        check({tag, " pend_hit1"}, 32'(pend_hit1), 32'(v.h1));
        check({tag, " pend_hit2"}, 32'(pend_hit2), 32'(v.h2));
        model_step(v);
        n_vec++;
        @(posedge clk);
        #1;
        check_port(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // pipe only, x0 pipe write, single lat drain
        vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      5, 0,  1, 0, 0);
        vt[1]  = mk(1, 0, 32'h1234,     0, 0, 0,      0, 0,  1, 0, 0);
        vt[2]  = mk(0, 0, 0,            1, 7, 32'h11, 7, 0,  1, 0, 0);
        vt[3]  = mk(0, 0, 0,            0, 0, 0,      7, 7,  1, 1, 1);
        vt[4]  = mk(0, 0, 0,            0, 0, 0,      7, 0,  1, 0, 0);
        // fill under continuous pipe writes, then drain in order
        vt[5]  = mk(1, 10, 32'hA0, 1, 1, 32'h101,     1, 0,  1, 0, 0);
        vt[6]  = mk(1, 10, 32'hA1, 1, 2, 32'h102,     1, 2,  1, 1, 0);
        vt[7]  = mk(1, 10, 32'hA2, 1, 3, 32'h103,     3, 2,  1, 0, 1);
        vt[8]  = mk(1, 10, 32'hA3, 1, 4, 32'h104,     4, 3,  1, 0, 1);
        vt[9]  = mk(1, 11, 32'hB1, 1, 6, 32'h66,      4, 6,  0, 1, 0);
        vt[10] = mk(0, 0, 0,       1, 6, 32'h66,      1, 6,  0, 1, 0);
        vt[11] = mk(0, 0, 0,       1, 6, 32'h66,      6, 2,  1, 0, 1);
        vt[12] = mk(0, 0, 0,       0, 0, 0,           6, 1,  1, 1, 0);
        vt[13] = mk(0, 0, 0,       0, 0, 0,           4, 3,  1, 1, 0);
        vt[14] = mk(0, 0, 0,       0, 0, 0,           6, 4,  1, 1, 0);
        // WAW squash
        vt[15] = mk(0, 0, 0,       1, 9, 32'hAA,      6, 0,  1, 0, 0);
        vt[16] = mk(1, 9, 32'hBB,  0, 0, 0,           9, 0,  1, 1, 0);
        vt[17] = mk(0, 0, 0,       0, 0, 0,           9, 0,  1, 0, 0);
        vt[18] = mk(0, 0, 0,       0, 0, 0,           9, 9,  1, 0, 0);
        // same-edge push and pipe write to one register
        vt[19] = mk(1, 3, 32'h2,   1, 3, 32'h1,       3, 0,  1, 0, 0);
        vt[20] = mk(0, 0, 0,       0, 0, 0,           3, 3,  1, 1, 1);
        // lat result to x0
        vt[21] = mk(0, 0, 0,       1, 0, 32'h55,      0, 3,  1, 0, 0);
        vt[22] = mk(0, 0, 0,       0, 0, 0,           0, 3,  1, 0, 0);
        // two entries squashed by one pipe write
        vt[23] = mk(1, 13, 32'h13, 1, 12, 32'hC1,     12, 0,  1, 0, 0);
        vt[24] = mk(1, 13, 32'h14, 1, 12, 32'hC2,     12, 13, 1, 1, 0);
        vt[25] = mk(1, 12, 32'hCC, 1, 14, 32'hE1,     12, 14, 1, 1, 0);
        vt[26] = mk(0, 0, 0,       0, 0, 0,           12, 14, 1, 0, 1);
        vt[27] = mk(0, 0, 0,       0, 0, 0,           12, 14, 1, 0, 1);
        vt[28] = mk(0, 0, 0,       0, 0, 0,           14, 0,  1, 1, 0);
        vt[29] = mk(0, 0, 0,       0, 0, 0,           14, 0,  1, 0, 0);
        // three entries buffered before an async reset
        rv[0]  = mk(1, 13, 32'h31, 1, 20, 32'h200,    20, 0,  1, 0, 0);
        rv[1]  = mk(1, 13, 32'h32, 1, 21, 32'h201,    20, 21, 1, 1, 0);
        rv[2]  = mk(1, 13, 32'h33, 1, 22, 32'h202,    21, 22, 1, 1, 0);

        rst = 1'b0;
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        lat_valid = 0; lat_waddr = 0; lat_wdata = 0;
        chk_raddr1 = 0; chk_raddr2 = 0;
        last_a = '0; last_d = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset we", 32'(we), 32'd0);
        check("reset waddr", 32'(waddr), 32'd0);
        check("reset wdata", wdata, 32'd0);
        check("reset lat_ready", 32'(lat_ready), 32'd1);
        check("reset pend_hit1", 32'(pend_hit1), 32'd0);
        check("reset pend_hit2", 32'(pend_hit2), 32'd0);
        n_vec++;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 30; i++) apply(vt[i], $sformatf("v%0d", i));
        for (int i = 0; i < 3; i++) apply(rv[i], $sformatf("r%0d", i));

        // Reset mid-cycle while the port is busy and three entries wait.
        pipe_we = 0; lat_valid = 0;
        chk_raddr1 = 5'd20; chk_raddr2 = 5'd22;
        #2;
        rst = 1'b0;
        #1;
        check("async we", 32'(we), 32'd0);
        check("async waddr", 32'(waddr), 32'd0);
        check("async lat_ready", 32'(lat_ready), 32'd1);
        check("async pend_hit1", 32'(pend_hit1), 32'd0);
        check("async pend_hit2", 32'(pend_hit2), 32'd0);
        n_vec++;
        mq.delete();
        sb.delete();
        last_a = '0; last_d = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 20, 22, 1, 0, 0), $sformatf("post_rst%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
